// File: rtl/vga_line_prefetch.sv
// vga_line_prefetch
//
// Purpose:
//    Double-buffered line prefetcher for a VGA scan-out path. It reads one
//    framebuffer line of four 32-bit words from SRAM over a Wishbone master
//    port into the back buffer. A swap pulse at line start then promotes the
//    back buffer to the front, where the pixel consumer reads it one word at
//    a time.
//
// Parameters:
//    BASE_ADDR    SRAM word address of framebuffer line 0
//    TIMEOUT_CYC  ack-wait cycle limit (only with VGA_PREFETCH_TIMEOUT_EN)
//
// Build option:
//    VGA_PREFETCH_TIMEOUT_EN  when defined, a word whose ack does not arrive
//                             within TIMEOUT_CYC cycles is filled with zero,
//                             timeout_err is set, and the fetch moves on.
//                             When undefined, the fetch waits indefinitely
//                             and timeout_err is tied low.
//
// Ports:
//    clk, rst           clock, synchronous active-high reset
//    VGA_state          0 inactive, 1 about to be active, 2 active
//    fetch_start        pulse: fetch line fetch_line into the back buffer
//    fetch_line         line index 0..95
//    swap               pulse at line start: back buffer becomes front
//    wb_cyc/stb/we      Wishbone master controls (read only, we = 0)
//    wb_adr, wb_sel     Wishbone word address and byte select
//    wb_dat_i, wb_ack   Wishbone read data and acknowledge
//    pix_word_idx       front-buffer word select
//    pix_word           selected front-buffer word (0 when not valid)
//    pix_valid          front buffer holds a complete line
//    underrun           sticky: swap arrived before the fetch completed
//    timeout_err        sticky: a word was replaced by zero after timeout

module vga_line_prefetch #(
   parameter logic [31:0] BASE_ADDR   = 32'h3E80,
   parameter int          TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  VGA_state,
   input  logic        fetch_start,
   input  logic [6:0]  fetch_line,
   input  logic        swap,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [31:0] wb_adr,
   output logic [3:0]  wb_sel,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack,
   input  logic [1:0]  pix_word_idx,
   output logic [31:0] pix_word,
   output logic        pix_valid,
   output logic        underrun,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      READY = 2'd2
   } state_t;

`ifdef VGA_PREFETCH_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   state_t      state;
   state_t      next_state;
   logic        ptr;
   logic [6:0]  line_q;
   logic [1:0]  word_cnt;
   logic [31:0] to_cnt;
   logic [31:0] line_buf [0:1][0:3];

   logic        vga_active;
   logic        fetching;
   logic        accept;
   logic        timeout_hit;
   logic        advance;
   logic [31:0] line_off;

   assign vga_active = (VGA_state != 2'd0);
   assign fetching   = (state == FETCH);
   assign accept     = (state == IDLE) && vga_active && fetch_start
                       && (fetch_line < 7'd96);

   // A real ack always wins over a timeout landing in the same cycle.
   assign timeout_hit = TIMEOUT_ON && fetching && vga_active && !wb_ack
                        && (to_cnt == 32'(TIMEOUT_CYC - 1));
   assign advance     = fetching && vga_active && (wb_ack || timeout_hit);

   // line * 4 widened to 32 bits before the add so line 95 cannot overflow.
   assign line_off = {23'd0, line_q, 2'b00};

   assign wb_cyc = fetching;
   assign wb_stb = fetching;
   assign wb_we  = 1'b0;
   assign wb_sel = fetching ? 4'hF : 4'h0;
   assign wb_adr = fetching ? (BASE_ADDR + line_off + {30'd0, word_cnt}) : 32'h0;

   assign pix_word = pix_valid ? line_buf[ptr][pix_word_idx] : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Losing VGA_state aborts whatever is in progress. In READY only a swap
   // leaves, so a fetch_start arriving with it is dropped.
   always_comb begin
      next_state = state;
      if (!vga_active) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) next_state = FETCH;
            FETCH:   if (advance && (word_cnt == 2'd3)) next_state = READY;
            READY:   if (swap) next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= 1'b0;
         line_q    <= 7'd0;
         word_cnt  <= 2'd0;
         to_cnt    <= 32'd0;
         pix_valid <= 1'b0;
         underrun  <= 1'b0;
      end else if (!vga_active) begin
         word_cnt  <= 2'd0;
         to_cnt    <= 32'd0;
         pix_valid <= 1'b0;
      end else begin
         if (accept) begin
            line_q   <= fetch_line;
            word_cnt <= 2'd0;
            to_cnt   <= 32'd0;
         end
         if (fetching) begin
            if (advance) begin
               word_cnt <= word_cnt + 2'd1;
               to_cnt   <= 32'd0;
            end else begin
               to_cnt   <= to_cnt + 32'd1;
            end
         end
         // An early swap keeps the old pointer so the fetch in flight
         // still lands in the back buffer.
         if (swap) begin
            if (state == READY) begin
               ptr       <= ~ptr;
               pix_valid <= 1'b1;
            end else begin
               underrun  <= 1'b1;
               pix_valid <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         line_buf[~ptr][word_cnt] <= timeout_hit ? 32'h0 : wb_dat_i;
      end
   end

`ifdef VGA_PREFETCH_TIMEOUT_EN
   logic timeout_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_err_q <= 1'b0;
      end else if (timeout_hit) begin
         timeout_err_q <= 1'b1;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/vga_line_prefetch.md
VGA_LINE_PREFETCH -- requirements
Module: vga_line_prefetch

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3E80, SRAM word address of framebuffer line 0.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16, ack-wait cycle limit; used only with VGA_PREFETCH_TIMEOUT_EN.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port VGA_state  in  2  0 = inactive, 1 = about to be active, 2 = active.
REQ-006 SHALL have port fetch_start  in  1  one-cycle pulse requesting a line fetch into the back buffer.
REQ-007 SHALL have port fetch_line  in  7  line index 0..95, sampled with fetch_start.
REQ-008 SHALL have port swap  in  1  one-cycle pulse at line start; promotes the back buffer to front.
REQ-009 SHALL have ports wb_cyc, wb_stb, wb_we  out  1 each  Wishbone master controls; wb_we is constant 0.
REQ-010 SHALL have port wb_adr  out  32  word address; wb_sel  out  4  byte select.
REQ-011 SHALL have ports wb_dat_i  in  32 and wb_ack  in  1  read data and acknowledge.
REQ-012 SHALL have port pix_word_idx  in  2  front-buffer word select (h_count[6:5] of the consumer).
REQ-013 SHALL have port pix_word  out  32  selected front-buffer word; pix_valid  out  1  front buffer holds a complete line.
REQ-014 SHALL have ports underrun, timeout_err  out  1 each  sticky error flags.

Function
REQ-015 SHALL hold two 4x32-bit line buffers (front, back); the front/back roles swap via a 1-bit pointer.
REQ-016 SHALL implement FSM IDLE -> FETCH -> READY -> IDLE.
REQ-017 In IDLE: fetch_start with fetch_line<96 and VGA_state!=0 SHALL latch the line, clear word_cnt, and enter FETCH next cycle; otherwise fetch_start SHALL be ignored.
REQ-018 In FETCH: wb_cyc=wb_stb=1, wb_sel=4'hF, wb_adr=BASE_ADDR+line*4+word_cnt, held stable until wb_ack.
REQ-019 On wb_ack in FETCH: wb_dat_i SHALL be written to back[word_cnt] in the same cycle. word_cnt==3 SHALL go to READY; otherwise word_cnt SHALL increment and the next address SHALL appear the following cycle.
REQ-020 wb_cyc/wb_stb SHALL be 0 in IDLE and READY; wb_adr and wb_sel SHALL be 0 when wb_cyc=0.
REQ-021 fetch_start received outside IDLE SHALL be ignored without any flag.
REQ-022 swap in READY SHALL toggle the pointer, set pix_valid=1, and return to IDLE, all in one edge.
REQ-023 swap in IDLE or FETCH SHALL set underrun, clear pix_valid, leave the pointer unchanged, and let any fetch continue.
REQ-024 swap and fetch_start in the same cycle while READY: the swap SHALL take effect, and the fetch SHALL start from IDLE only on a later pulse.
REQ-025 pix_word SHALL be combinational: front[pix_word_idx] when pix_valid=1, else 32'h0.
REQ-026 VGA_state==0 for any cycle SHALL abort FETCH (cyc/stb drop next edge), return to IDLE, and clear pix_valid; error flags SHALL be retained.
REQ-027 Address arithmetic SHALL be 32-bit unsigned with wrap; line*4 SHALL be computed in at least 9 bits.

Reset
REQ-028 rst=1 at a clock edge SHALL force: state IDLE, pointer 0, word_cnt 0, pix_valid 0, underrun 0, timeout_err 0, wb_cyc/wb_stb 0, and the timeout counter 0.
REQ-029 rst asserted mid-FETCH SHALL drop wb_cyc/wb_stb on that edge; buffer contents need not be cleared.

Configuration
REQ-030 With VGA_PREFETCH_TIMEOUT_EN defined, FETCH SHALL count cycles without wb_ack. When the count reaches TIMEOUT_CYC, the block SHALL write 32'h0 to back[word_cnt], set timeout_err, and advance exactly as on an ack.
REQ-031 Without VGA_PREFETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely for wb_ack, and timeout_err SHALL be tied to 0.

Verification
REQ-032 Basic fetch: fetch_line=5, acks after 1 cycle each -> addresses 0x3E94..0x3E97 in order; READY after 4 acks; swap -> pix_valid=1 and pix_word matches the data per index.
REQ-033 Ack wait-states: 3-cycle ack delay per word -> address and strobe held stable for 3 cycles each; data captured only on ack.
REQ-034 Early swap: swap after 2 of 4 acks -> underrun=1, pix_valid=0, fetch completes, and the next swap -> pix_valid=1.
REQ-035 Abort: VGA_state=0 during the 2nd word -> wb_cyc=0 next cycle, state IDLE; fetch_start with line 96 -> ignored.
REQ-036 Timeout (macro defined): no ack for 16 cycles on word 1 -> back[1]=0, timeout_err=1, word 2 requested next.
REQ-037 Reset mid-fetch: rst during word 2 -> all outputs at REQ-028 values next cycle.
